// File: rtl/axis_stream_pkg.sv
// Shared defaults and width helpers for the AXI4-Stream master slice.
package axis_stream_pkg;

  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned AXIS_DEPTH  = 8;
  localparam int unsigned AXIS_LEN_W  = 16;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two >= 2.
module axis_sync_fifo
  import axis_stream_pkg::*;
#(
  parameter int unsigned DATA_W = AXIS_DATA_W,
  parameter int unsigned DEPTH  = AXIS_DEPTH
) (
  input  logic                      ACLK,
  input  logic                      ARSTN,
  input  logic                      push,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         rd_data,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Pointers are exactly AW bits wide, so natural overflow is the modulo-DEPTH wrap.
  always_ff @(posedge ACLK) begin
    if (!ARSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    rd_data = mem[rd_ptr];
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
  end

endmodule

// File: rtl/axis_stream_master.sv
// AXI4-Stream master: FIFO-buffered push port, registered output stage, TLAST from PKT_LEN.
// Optional AXIS_STREAM_MASTER_STATS_EN adds PKT_DONE_CNT and STALL_CNT outputs.
module axis_stream_master
  import axis_stream_pkg::*;
#(
  parameter int unsigned DATA_W = AXIS_DATA_W,
  parameter int unsigned DEPTH  = AXIS_DEPTH,
  parameter int unsigned LEN_W  = AXIS_LEN_W
) (
  input  logic                      ACLK,
  input  logic                      ARSTN,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [DATA_W-1:0]         IN_DATA,
  input  logic [LEN_W-1:0]          PKT_LEN,
  output logic                      TVALID,
  input  logic                      TREADY,
  output logic [DATA_W-1:0]         M_TDATA,
  output logic                      TLAST,
  output logic [cnt_w(DEPTH)-1:0]   FIFO_COUNT,
  output logic                      FULL,
  output logic                      EMPTY
`ifdef AXIS_STREAM_MASTER_STATS_EN
  ,
  output logic [31:0]               PKT_DONE_CNT,
  output logic [31:0]               STALL_CNT
`endif
);

  logic              push;
  logic              load;
  logic [DATA_W-1:0] head;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_eff;
  logic              last_next;

  axis_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARSTN   (ARSTN),
    .push    (push),
    .wr_data (IN_DATA),
    .pop     (load),
    .rd_data (head),
    .count   (FIFO_COUNT),
    .full    (FULL),
    .empty   (EMPTY)
  );

  // TREADY only reaches the FIFO pop and register enables, never TVALID/M_TDATA directly.
  always_comb begin
    IN_READY  = !FULL;
    push      = IN_VALID && !FULL;
    load      = !EMPTY && (!TVALID || TREADY);
    len_eff   = len_q;
    if (beat_cnt == '0) begin
      len_eff = (PKT_LEN == '0) ? LEN_W'(1) : PKT_LEN;
    end
    last_next = (beat_cnt == len_eff - LEN_W'(1));
  end

  always_ff @(posedge ACLK) begin
    if (!ARSTN) begin
      TVALID   <= 1'b0;
      M_TDATA  <= '0;
      TLAST    <= 1'b0;
      beat_cnt <= '0;
      len_q    <= LEN_W'(1);
    end else if (load) begin
      TVALID   <= 1'b1;
      M_TDATA  <= head;
      TLAST    <= last_next;
      len_q    <= len_eff;
      beat_cnt <= last_next ? '0 : beat_cnt + LEN_W'(1);
    end else if (TVALID && TREADY) begin
      TVALID <= 1'b0;
    end
  end

`ifdef AXIS_STREAM_MASTER_STATS_EN
  always_ff @(posedge ACLK) begin
    if (!ARSTN) begin
      PKT_DONE_CNT <= '0;
      STALL_CNT    <= '0;
    end else begin
      if (TVALID && TREADY && TLAST) PKT_DONE_CNT <= PKT_DONE_CNT + 32'd1;
      if (TVALID && !TREADY)         STALL_CNT    <= STALL_CNT + 32'd1;
    end
  end
`endif

endmodule
